// File: rtl/css_mcu0_el2_ccm_bank_ctrl.sv
// SRAM-side bank controller for an EL2 closely-coupled memory (ICCM/DCCM).
// Passes core bank accesses to the macros, runs a zero-fill init engine and aligns read data to RD_LAT.
module css_mcu0_el2_ccm_bank_ctrl #(
  parameter int unsigned       NUM_BANKS = 4,
  parameter int unsigned       DEPTH     = 4096,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ECC_W     = 7,
  parameter int unsigned       RD_LAT    = 1,
  parameter logic [ECC_W-1:0]  INIT_ECC  = '0,
  localparam int unsigned      ADDR_W    = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_BANKS-1:0]                  core_clken,
  input  logic [NUM_BANKS-1:0]                  core_wren,
  input  logic [NUM_BANKS*ADDR_W-1:0]           core_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]           core_wdata,
  input  logic [NUM_BANKS*ECC_W-1:0]            core_wecc,
  output logic [NUM_BANKS*DATA_W-1:0]           core_dout,
  output logic [NUM_BANKS*ECC_W-1:0]            core_decc,
  input  logic                                  init_req,
  output logic                                  init_busy,
  output logic                                  init_done,
  output logic                                  access_err,
  input  logic                                  err_clr,
  output logic [NUM_BANKS-1:0]                  sram_cs,
  output logic [NUM_BANKS-1:0]                  sram_we,
  output logic [NUM_BANKS*ADDR_W-1:0]           sram_addr,
  output logic [NUM_BANKS*(DATA_W+ECC_W)-1:0]   sram_wdata,
  input  logic [NUM_BANKS*(DATA_W+ECC_W)-1:0]   sram_rdata
);

  localparam int unsigned WORD_W = DATA_W + ECC_W;
  localparam int unsigned VLD_N  = (RD_LAT > 1) ? RD_LAT - 1 : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_INIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              in_init;

  assign in_init = (state_q == ST_INIT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (init_req) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      ST_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A new violation in the same cycle as err_clr keeps the flag set.
  always_comb begin
    err_d = err_q;
    if (in_init && (|core_clken)) err_d = 1'b1;
    else if (err_clr)             err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign init_busy  = in_init;
  assign init_done  = done_q;
  assign access_err = err_q;

  always_comb begin
    sram_cs    = '0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (in_init) begin
      sram_cs    = '1;
      sram_we    = '1;
      sram_addr  = {NUM_BANKS{cnt_q}};
      sram_wdata = {NUM_BANKS{INIT_ECC, {DATA_W{1'b0}}}};
    end else begin
      sram_cs   = core_clken;
      sram_we   = core_clken & core_wren;
      sram_addr = core_addr;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        sram_wdata[b*WORD_W +: WORD_W] = {core_wecc[b*ECC_W +: ECC_W], core_wdata[b*DATA_W +: DATA_W]};
      end
    end
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    logic [VLD_N-1:0]  vld_q, vld_d;
    logic [WORD_W-1:0] rword;

    // vld_q[k] marks that fresh read data entered stage k on the last edge (stage 0 = macro output).
    always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = sram_cs[g] & ~sram_we[g];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) vld_q <= '0;
      else     vld_q <= vld_d;
    end

    if (RD_LAT == 1) begin : g_lat1
      logic [WORD_W-1:0] hold_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst)           hold_q <= '0;
        else if (vld_q[0]) hold_q <= sram_rdata[g*WORD_W +: WORD_W];
      end

      assign rword = vld_q[0] ? sram_rdata[g*WORD_W +: WORD_W] : hold_q;
    end else begin : g_latn
      logic [WORD_W-1:0] stg_q [RD_LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int unsigned k = 0; k < RD_LAT - 1; k++) stg_q[k] <= '0;
        end else begin
          if (vld_q[0]) stg_q[0] <= sram_rdata[g*WORD_W +: WORD_W];
          for (int unsigned k = 1; k < RD_LAT - 1; k++) begin
            if (vld_q[k]) stg_q[k] <= stg_q[k-1];
          end
        end
      end

      assign rword = stg_q[RD_LAT-2];
    end

    assign core_dout[g*DATA_W +: DATA_W] = rword[DATA_W-1:0];
    assign core_decc[g*ECC_W +: ECC_W]   = rword[WORD_W-1:DATA_W];
  end

endmodule
